midi_msg_tx: RTL

//  Upstream stage of the UART transmitter: accepts one complete MIDI message per handshake.

---
 rtl/midi_msg_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/midi_msg_tx.sv
//==============================================================================
// Module      : midi_msg_tx
// Description : MIDI message serialiser feeding a UART transmitter. Accepts a
//               complete message (status + up to two data bytes) in one
//               handshake, decodes the message length from the status byte
//               and streams 1-3 bytes over a valid/ready byte interface.
//               Undefined / data-range status bytes are dropped with an err
//               pulse.
//               Optional feature macro: MIDI_RUNNING_STATUS_EN
//               (running-status compression of channel-voice messages).
// Ports       : clk, reset_n (async, active-low)
//               msg_valid/msg_ready/msg_status/msg_d1/msg_d2 : message input
//               tx_valid/tx_ready/tx_data                    : byte output
//               busy (not idle), err (one-cycle drop pulse)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module midi_msg_tx #(
    parameter int RS_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_d1,
    input  logic [7:0] msg_d2,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ST   = 2'd1;
    localparam logic [1:0] S_D1   = 2'd2;
    localparam logic [1:0] S_D2   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_status;
    logic [6:0] r_d1;
    logic [6:0] r_d2;
    logic [1:0] r_len;
    logic       r_tx_valid;
    logic [7:0] r_tx_data;
    logic       r_err;

    logic       w_accept;
    logic [1:0] w_len;          // 0 means the status byte is not transmittable
    logic       w_drop;
    logic       w_skip_st;      // running status hit: start at the first data byte
    logic       w_tx_valid_nxt;
    logic [7:0] w_tx_data_nxt;

    // Data bytes are 7-bit; their top bits are deliberately discarded.
    logic       w_unused_dbits;
    assign w_unused_dbits = msg_d1[7] ^ msg_d2[7];

    assign w_accept = msg_valid && (r_state == S_IDLE);
    assign w_drop   = (w_len == 2'd0);

    // Message length from status byte
    always_comb begin
        w_len = 2'd0;
        if (msg_status[7]) begin
            case (msg_status[7:4])
                4'hC, 4'hD: w_len = 2'd2;
                4'hF: begin
                    if (msg_status[3]) begin
                        w_len = 2'd1;                   // F8-FF real-time
                    end else begin
                        case (msg_status[2:0])
                            3'd1, 3'd3: w_len = 2'd2;
                            3'd2:       w_len = 2'd3;
                            3'd6:       w_len = 2'd1;
                            default:    w_len = 2'd0;   // F0, F4, F5, F7
                        endcase
                    end
                end
                default: w_len = 2'd3;                  // 8x, 9x, Ax, Bx, Ex
            endcase
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    localparam int               CNT_W = $clog2(RS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TO  = CNT_W'(RS_TIMEOUT);

    logic [7:0]       r_rs_reg;
    logic             r_rs_vld;
    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_chan_voice;

    assign w_chan_voice = msg_status[7] && (msg_status[7:4] != 4'hF);
    // The counter compare covers the accept that lands on the very cycle the
    // timeout is reached, before r_rs_vld itself has been cleared.
    assign w_skip_st    = w_chan_voice && r_rs_vld && (r_idle_cnt != C_TO)
                          && (msg_status == r_rs_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs_reg   <= 8'h00;
            r_rs_vld   <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_idle_cnt <= '0;
            end else if ((r_state == S_IDLE) && (r_idle_cnt != C_TO)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (r_idle_cnt == C_TO) begin
                r_rs_vld <= 1'b0;
            end

            // Later assignments override the timeout clear above.
            if (w_accept && !w_drop) begin
                if (w_chan_voice) begin
                    r_rs_reg <= msg_status;
                    r_rs_vld <= 1'b1;
                end else if (!msg_status[3]) begin
                    r_rs_vld <= 1'b0;                   // F1, F2, F3, F6
                end
            end
        end
    end
`else
    logic [31:0] w_unused_rs_timeout;
    assign w_unused_rs_timeout = RS_TIMEOUT;
    assign w_skip_st           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_drop) begin
                    w_state_nxt = w_skip_st ? S_D1 : S_ST;
                end
            end
            S_ST: begin
                if (tx_ready) begin
                    w_state_nxt = (r_len == 2'd1) ? S_IDLE : S_D1;
                end
            end
            S_D1: begin
                if (tx_ready) begin
                    w_state_nxt = (r_len == 2'd2) ? S_IDLE : S_D2;
                end
            end
            S_D2: begin
                if (tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered byte interface. On the
    // accept cycle the message registers are not yet loaded, so the byte is
    // taken straight from the inputs.
    always_comb begin
        w_tx_valid_nxt = (w_state_nxt != S_IDLE);
        w_tx_data_nxt  = r_tx_data;
        case (w_state_nxt)
            S_ST:    w_tx_data_nxt = (r_state == S_IDLE) ? msg_status : r_status;
            S_D1:    w_tx_data_nxt = (r_state == S_IDLE) ? {1'b0, msg_d1[6:0]}
                                                         : {1'b0, r_d1};
            S_D2:    w_tx_data_nxt = {1'b0, r_d2};
            default: w_tx_data_nxt = r_tx_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_status   <= 8'h00;
            r_d1       <= 7'h00;
            r_d2       <= 7'h00;
            r_len      <= 2'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_status <= msg_status;
                r_d1     <= msg_d1[6:0];
                r_d2     <= msg_d2[6:0];
                r_len    <= w_len;
            end
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_err      <= w_accept && w_drop;
        end
    end

    assign msg_ready = (r_state == S_IDLE);
    assign busy      = ~msg_ready;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign err       = r_err;

endmodule

`default_nettype wire
